// File: rtl/text_console_writer.sv
// Text console writer: turns a character/control byte stream into text RAM
// writes, tracking the cursor and a hardware scroll base, with row and
// full-screen clear bursts.
module text_console_writer #(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 30,
  parameter int unsigned ADDR_W     = 12,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  input  logic [7:0]        in_attr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [5:0]        cursor_row,
  output logic [6:0]        cursor_col,
  output logic [5:0]        row_base,
  output logic              busy
);

  localparam int unsigned ROW_W  = 6;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CELLS  = COLS * ROWS;

  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W:0]    ROWS_EXT  = (ROW_W + 1)'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] COLS_M1_A = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  localparam logic [DATA_W-1:0] BLANK_W   = {8'h00, BLANK_CHAR};

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_CHAR,
    ST_CLR_ROW,
    ST_CLR_ALL
  } state_t;

  state_t              r_state, w_state;
  logic                r_in_ready, w_in_ready;
  logic                r_wr_en, w_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr;
  logic [DATA_W-1:0]   r_wr_data, w_wr_data;
  logic [ROW_W-1:0]    r_cursor_row, w_cursor_row;
  logic [COL_W-1:0]    r_cursor_col, w_cursor_col;
  logic [ROW_W-1:0]    r_row_base, w_row_base;
  logic                r_busy, w_busy;
  logic                r_scroll_pend, w_scroll_pend;
  logic [ADDR_W-1:0]   r_clr_end, w_clr_end;

  logic [ROW_W:0]      w_row_sum;
  logic [ROW_W-1:0]    w_phys_row;
  logic [ROW_W-1:0]    w_row_base_inc;
  logic [ADDR_W-1:0]   w_char_addr;
  logic [ADDR_W-1:0]   w_base_start;
  logic                w_accept;
  logic                w_printable;

  // Physical row of the cursor, scroll-base increment and derived addresses
  always_comb begin
    w_row_sum      = {1'b0, r_row_base} + {1'b0, r_cursor_row};
    w_phys_row     = (w_row_sum >= ROWS_EXT) ? ROW_W'(w_row_sum - ROWS_EXT)
                                             : ROW_W'(w_row_sum);
    w_row_base_inc = (r_row_base == LAST_ROW) ? '0 : r_row_base + 1'b1;
    w_char_addr    = ADDR_W'(w_phys_row) * COLS_A + ADDR_W'(r_cursor_col);
    w_base_start   = ADDR_W'(r_row_base) * COLS_A;
    w_accept       = in_valid && r_in_ready;
    w_printable    = (in_char >= 8'h20) && (in_char <= 8'h7E);
  end

  // Next-state and next-output decode
  always_comb begin
    w_state       = r_state;
    w_in_ready    = r_in_ready;
    w_wr_en       = 1'b0;
    w_wr_addr     = r_wr_addr;
    w_wr_data     = r_wr_data;
    w_cursor_row  = r_cursor_row;
    w_cursor_col  = r_cursor_col;
    w_row_base    = r_row_base;
    w_busy        = r_busy;
    w_scroll_pend = r_scroll_pend;
    w_clr_end     = r_clr_end;

    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (w_accept) begin
          if (w_printable) begin
            w_state    = ST_WR_CHAR;
            w_in_ready = 1'b0;
            w_wr_en    = 1'b1;
            w_wr_addr  = w_char_addr;
            w_wr_data  = {in_attr, in_char};
            if (r_cursor_col == LAST_COL) begin
              w_cursor_col = '0;
              if (r_cursor_row != LAST_ROW) begin
                w_cursor_row = r_cursor_row + 1'b1;
              end else begin
                // Scroll after the character write; old base row gets cleared
                w_row_base    = w_row_base_inc;
                w_scroll_pend = 1'b1;
                w_clr_end     = w_base_start + COLS_M1_A;
              end
            end else begin
              w_cursor_col = r_cursor_col + 1'b1;
            end
          end else begin
            case (in_char)
              CH_CR: w_cursor_col = '0;
              CH_BS: begin
                if (r_cursor_col != '0) begin
                  w_cursor_col = r_cursor_col - 1'b1;
                end
              end
              CH_LF: begin
                if (r_cursor_row != LAST_ROW) begin
                  w_cursor_row = r_cursor_row + 1'b1;
                end else begin
                  w_row_base = w_row_base_inc;
                  w_state    = ST_CLR_ROW;
                  w_in_ready = 1'b0;
                  w_busy     = 1'b1;
                  w_wr_en    = 1'b1;
                  w_wr_addr  = w_base_start;
                  w_wr_data  = BLANK_W;
                  w_clr_end  = w_base_start + COLS_M1_A;
                end
              end
              CH_FF: begin
                w_cursor_row = '0;
                w_cursor_col = '0;
                w_row_base   = '0;
                w_state      = ST_CLR_ALL;
                w_in_ready   = 1'b0;
                w_busy       = 1'b1;
                w_wr_en      = 1'b1;
                w_wr_addr    = '0;
                w_wr_data    = BLANK_W;
                w_clr_end    = LAST_CELL;
              end
              default: ;
            endcase
          end
        end
      end

      ST_WR_CHAR: begin
        if (r_scroll_pend) begin
          w_scroll_pend = 1'b0;
          w_state       = ST_CLR_ROW;
          w_busy        = 1'b1;
          w_wr_en       = 1'b1;
          w_wr_addr     = r_clr_end - COLS_M1_A;
          w_wr_data     = BLANK_W;
        end else begin
          w_state    = ST_IDLE;
          w_in_ready = 1'b1;
        end
      end

      ST_CLR_ROW, ST_CLR_ALL: begin
        if (r_wr_addr == r_clr_end) begin
          w_state    = ST_IDLE;
          w_busy     = 1'b0;
          w_in_ready = 1'b1;
        end else begin
          w_wr_en   = 1'b1;
          w_wr_addr = r_wr_addr + 1'b1;
          w_wr_data = BLANK_W;
        end
      end

      default: w_state = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_in_ready    <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_cursor_row  <= '0;
      r_cursor_col  <= '0;
      r_row_base    <= '0;
      r_busy        <= 1'b0;
      r_scroll_pend <= 1'b0;
      r_clr_end     <= '0;
    end else begin
      r_state       <= w_state;
      r_in_ready    <= w_in_ready;
      r_wr_en       <= w_wr_en;
      r_wr_addr     <= w_wr_addr;
      r_wr_data     <= w_wr_data;
      r_cursor_row  <= w_cursor_row;
      r_cursor_col  <= w_cursor_col;
      r_row_base    <= w_row_base;
      r_busy        <= w_busy;
      r_scroll_pend <= w_scroll_pend;
      r_clr_end     <= w_clr_end;
    end
  end

  assign in_ready   = r_in_ready;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign cursor_row = r_cursor_row;
  assign cursor_col = r_cursor_col;
  assign row_base   = r_row_base;
  assign busy       = r_busy;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed testbench for text_console_writer: logs every RAM write and
// compares against hand-computed addresses, data and cursor values.
module tb_text_console_writer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic [7:0]  in_attr;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic [5:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic [5:0]  row_base;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;
  int n_clr_viol = 0;
  int cyc = 0;

  logic [11:0] q_addr[$];
  logic [15:0] q_data[$];
  int          q_cyc[$];

  text_console_writer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .in_attr    (in_attr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .row_base   (row_base),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle stamp for write-gap checks
  always @(posedge clk) cyc <= cyc + 1;

  // Write logger; blank-cell writes must happen with busy=1, in_ready=0
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
      q_cyc.push_back(cyc);
      if (wr_data == 16'h0020 && (busy !== 1'b1 || in_ready !== 1'b0))
        n_clr_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sample point just after the falling edge, after the logger has run
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] ch, input logic [7:0] at);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_char  = ch;
    in_attr  = at;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (in_ready === 1'b1) begin
        @(posedge clk);
        step();
        done = 1;
      end else begin
        step();
      end
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (in_ready === 1'b1 && busy === 1'b0) done = 1;
      else step();
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic send_n(input logic [7:0] ch, input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(ch, 8'h07);
      wait_idle();
    end
  endtask

  initial begin
    int nb;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_char  = 8'h00;
    in_attr  = 8'h00;

    // Reset state
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_cursor", {cursor_row, cursor_col}, 0);
    check("rst_row_base", row_base, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    step();
    check("rel_in_ready", in_ready, 1);

    // Single printable
    clear_log();
    send_byte(8'h41, 8'h07);
    check("a_cursor_col_now", cursor_col, 1);
    wait_idle();
    check("a_nwr", q_addr.size(), 1);
    check("a_addr", q_addr[0], 0);
    check("a_data", q_data[0], 16'h0741);
    check("a_cursor", {cursor_row, cursor_col}, {6'd0, 7'd1});

    // "AB", CR, LF, 'C', plus an ignored control byte
    do_reset();
    clear_log();
    send_n(8'h41, 1);
    send_n(8'h42, 1);
    send_n(8'h0D, 1);
    check("cr_col", cursor_col, 0);
    send_n(8'h0A, 1);
    check("lf_row", cursor_row, 1);
    send_n(8'h01, 1);
    send_n(8'h43, 1);
    check("abc_nwr", q_addr.size(), 3);
    check("abc_addr0", q_addr[0], 0);
    check("abc_addr1", q_addr[1], 1);
    check("abc_addr2", q_addr[2], 80);
    check("abc_data2", q_data[2], 16'h0743);
    check("abc_cursor", {cursor_row, cursor_col}, {6'd1, 7'd1});

    // 80 chars wrap to next row; BS at col 0 and col 1
    do_reset();
    clear_log();
    send_n(8'h78, 80);
    check("wrap_nwr", q_addr.size(), 80);
    check("wrap_last_addr", q_addr[79], 79);
    check("wrap_cursor", {cursor_row, cursor_col}, {6'd1, 7'd0});
    send_n(8'h08, 1);
    check("bs_col0", {cursor_row, cursor_col}, {6'd1, 7'd0});
    send_n(8'h7A, 1);
    check("z_addr", q_addr[80], 80);
    send_n(8'h08, 1);
    check("bs_col1", {cursor_row, cursor_col}, {6'd1, 7'd0});

    // Scroll from row 29, char held during the burst
    do_reset();
    send_n(8'h0A, 29);
    check("row29", cursor_row, 29);
    clear_log();
    send_byte(8'h0A, 8'h00);
    check("scr_busy", busy, 1);
    check("scr_ready", in_ready, 0);
    check("scr_base", row_base, 1);
    check("scr_row", cursor_row, 29);
    send_byte(8'h51, 8'h1E);
    wait_idle();
    check("scr_nwr", q_addr.size(), 81);
    nb = 0;
    for (int i = 0; i < 80 && i < q_addr.size(); i++)
      if (q_addr[i] != 12'(i) || q_data[i] != 16'h0020) nb++;
    check("scr_burst", nb, 0);
    if (q_addr.size() > 80) begin
      check("scr_q_addr", q_addr[80], 0);
      check("scr_q_data", q_data[80], 16'h1E51);
    end
    check("scr_viol", n_clr_viol, 0);
    check("scr_cursor", {cursor_row, cursor_col}, {6'd29, 7'd1});

    // Row base wraps 29 -> 0 after 30 scrolls total
    send_n(8'h0A, 28);
    check("base29", row_base, 29);
    clear_log();
    send_n(8'h0A, 1);
    check("wrapb_base", row_base, 0);
    check("wrapb_nwr", q_addr.size(), 80);
    check("wrapb_first", q_addr[0], 2320);
    check("wrapb_last", q_addr[79], 2399);
    clear_log();
    send_n(8'h0D, 1);
    send_n(8'h52, 1);
    check("r_addr", q_addr[0], 2320);

    // Printable at (29,79): char write then clear burst, no gap
    send_n(8'h6B, 78);
    check("col79", cursor_col, 79);
    clear_log();
    send_n(8'h57, 1);
    check("ws_nwr", q_addr.size(), 81);
    check("ws_char_addr", q_addr[0], 2399);
    check("ws_char_data", q_data[0], 16'h0757);
    check("ws_clr_first", q_addr[1], 0);
    check("ws_clr_last", q_addr[80], 79);
    check("ws_gap", q_cyc[1] - q_cyc[0], 1);
    check("ws_state", {row_base, cursor_row, cursor_col}, {6'd1, 6'd29, 7'd0});

    // FF, then reset after 100 clear writes
    clear_log();
    send_byte(8'h0C, 8'h00);
    check("ff_state", {row_base, cursor_row, cursor_col}, 0);
    check("ff_busy", busy, 1);
    begin
      bit done;
      done = 0;
      for (int i = 0; i < 500 && !done; i++) begin
        if (q_addr.size() >= 100) done = 1;
        else step();
      end
      if (!done) check("ff_timeout", 32'd0, 32'd1);
    end
    rst = 1'b0;
    #1;
    check("ff_rst_wr_en", wr_en, 0);
    step();
    step();
    step();
    check("ff_nwr", q_addr.size(), 100);
    nb = 0;
    for (int i = 0; i < q_addr.size(); i++)
      if (q_addr[i] != 12'(i)) nb++;
    check("ff_asc", nb, 0);
    check("ff_rst_ready", in_ready, 0);
    check("ff_rst_busy", busy, 0);
    check("ff_rst_addr", {wr_addr, wr_data}, 0);
    check("ff_rst_pos", {row_base, cursor_row, cursor_col}, 0);
    rst = 1'b1;
    step();
    check("ff_rel_ready", in_ready, 1);
    check("ff_rel_nwr", q_addr.size(), 100);
    check("all_viol", n_clr_viol, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
